// File: rtl/mouse_master_sm.sv
// mouse_master_sm: PS/2 mouse host controller; power-up handshake then 3-byte packet decode.
// Optional MOUSE_PKT_RESYNC_EN: header bit3 realignment plus inter-byte gap timeout.
module mouse_master_sm #(
   parameter int STARTUP_CYCLES = 5000000,
   parameter int TIMEOUT_CYCLES = 50000000,
   parameter int PKT_GAP_CYCLES = 100000
) (
   input  logic       CLK,
   input  logic       RESET,
   output logic       SEND_BYTE,
   output logic [7:0] BYTE_TO_SEND,
   input  logic       BYTE_SENT,
   output logic       READ_ENABLE,
   input  logic [7:0] BYTE_READ,
   input  logic [1:0] BYTE_ERROR_CODE,
   input  logic       BYTE_READY,
   output logic [7:0] MOUSE_STATUS,
   output logic [7:0] MOUSE_DX,
   output logic [7:0] MOUSE_DY,
   output logic       SEND_INTERRUPT,
   output logic       INIT_DONE,
   output logic [3:0] MASTER_STATE
);
   localparam int LIM_A = STARTUP_CYCLES > TIMEOUT_CYCLES ? STARTUP_CYCLES : TIMEOUT_CYCLES;
   localparam int LIM = LIM_A > PKT_GAP_CYCLES ? LIM_A : PKT_GAP_CYCLES;
   localparam logic [31:0] CNT_MAX = 32'(LIM - 1);
   localparam logic [31:0] STARTUP_LAST = 32'(STARTUP_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   typedef enum logic [3:0] {
      S_STARTUP, S_SEND_RESET, S_WAIT_RESET_SENT, S_WAIT_ACK1, S_WAIT_SELFTEST,
      S_WAIT_ID, S_SEND_ENABLE, S_WAIT_ENABLE_SENT, S_WAIT_ACK2, S_PKT1, S_PKT2,
      S_PKT3, S_PUBLISH
   } state_t;
   state_t      state_q, state_d;
   logic [31:0] cnt_q;
   logic [7:0]  stat_q, dx_q;
   logic        good, tmo, hdr_ok, gap;
   logic [7:0]  exp_b;
   assign good = BYTE_READY && BYTE_ERROR_CODE == 2'b00;
   assign tmo = cnt_q == TIMEOUT_LAST;
   assign exp_b = state_q == S_WAIT_SELFTEST ? 8'hAA : state_q == S_WAIT_ID ? 8'h00 : 8'hFA;
   assign MASTER_STATE = state_q;
`ifdef MOUSE_PKT_RESYNC_EN
   assign hdr_ok = BYTE_READ[3];
   assign gap = cnt_q == 32'(PKT_GAP_CYCLES - 1);
`else
   assign hdr_ok = 1'b1;
   assign gap = 1'b0;
`endif
   // Handshake states advance by +1 on success; any failure or timeout re-sends FF.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_STARTUP:         state_d = cnt_q == STARTUP_LAST ? S_SEND_RESET : state_q;
         S_SEND_RESET:      state_d = S_WAIT_RESET_SENT;
         S_SEND_ENABLE:     state_d = S_WAIT_ENABLE_SENT;
         S_WAIT_RESET_SENT,
         S_WAIT_ENABLE_SENT: state_d = BYTE_SENT ? state_t'(state_q + 4'd1) : tmo ? S_SEND_RESET : state_q;
         S_WAIT_ACK1, S_WAIT_SELFTEST, S_WAIT_ID, S_WAIT_ACK2:
            state_d = BYTE_READY ? (good && BYTE_READ == exp_b ? state_t'(state_q + 4'd1) : S_SEND_RESET)
                    : tmo ? S_SEND_RESET : state_q;
         S_PKT1:            state_d = good && hdr_ok ? S_PKT2 : S_PKT1;
         S_PKT2:            state_d = BYTE_READY ? (good ? S_PKT3 : S_PKT1) : gap ? S_PKT1 : state_q;
         S_PKT3:            state_d = BYTE_READY ? (good ? S_PUBLISH : S_PKT1) : gap ? S_PKT1 : state_q;
         S_PUBLISH:         state_d = S_PKT1;
         default:           state_d = S_STARTUP;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q        <= S_STARTUP;
         cnt_q          <= '0;
         stat_q         <= '0;
         dx_q           <= '0;
         SEND_BYTE      <= 1'b0;
         BYTE_TO_SEND   <= '0;
         READ_ENABLE    <= 1'b0;
         MOUSE_STATUS   <= '0;
         MOUSE_DX       <= '0;
         MOUSE_DY       <= '0;
         SEND_INTERRUPT <= 1'b0;
         INIT_DONE      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= state_d != state_q ? '0 : cnt_q == CNT_MAX ? cnt_q : cnt_q + 32'd1;
         SEND_BYTE      <= state_d == S_SEND_RESET || state_d == S_SEND_ENABLE;
         BYTE_TO_SEND   <= state_d == S_SEND_RESET ? 8'hFF : state_d == S_SEND_ENABLE ? 8'hF4 : BYTE_TO_SEND;
         READ_ENABLE    <= state_d inside {S_WAIT_ACK1, S_WAIT_SELFTEST, S_WAIT_ID, S_WAIT_ACK2,
                                           S_PKT1, S_PKT2, S_PKT3, S_PUBLISH};
         INIT_DONE      <= state_d >= S_PKT1;
         SEND_INTERRUPT <= state_d == S_PUBLISH;
         if (state_q == S_PKT1 && state_d == S_PKT2) stat_q <= BYTE_READ;
         if (state_q == S_PKT2 && state_d == S_PKT3) dx_q <= BYTE_READ;
         if (state_d == S_PUBLISH) begin
            MOUSE_STATUS <= stat_q;
            MOUSE_DX     <= dx_q;
            MOUSE_DY     <= BYTE_READ;
         end
      end
   end
endmodule

// File: doc/mouse_master_sm.md
Name: mouse_master_sm

Overview:
- Host-side controller for the PS/2 mouse link.
- Sequences the byte transmitter and the byte receiver (MouseReceiver) through the mouse power-up handshake, then decodes the 3-byte stream-mode packets.
- Publishes status, dX and dY with a one-cycle interrupt pulse.
- Sits between the PS/2 transceiver pair and the mouse position/display logic.

Parameters:
- STARTUP_CYCLES, 5000000: idle delay after reset before the first command (100 ms at 50 MHz).
- TIMEOUT_CYCLES, 50000000: maximum cycles spent in any init wait state before restarting (1 s).
- PKT_GAP_CYCLES, 100000: maximum cycles between packet bytes; used only with the optional feature.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- SEND_BYTE  out  1  one-cycle pulse; transmitter starts sending BYTE_TO_SEND
- BYTE_TO_SEND  out  8  command byte; held stable from the SEND_BYTE pulse until BYTE_SENT
- BYTE_SENT  in  1  one-cycle pulse from transmitter: command fully sent
- READ_ENABLE  out  1  enables the receiver
- BYTE_READ  in  8  byte from receiver; valid when BYTE_READY=1
- BYTE_ERROR_CODE  in  2  receiver error: 00 ok, bit0 parity, bit1 stop-bit
- BYTE_READY  in  1  one-cycle pulse: receiver byte valid
- MOUSE_STATUS  out  8  packet byte 1 (buttons, signs, overflow)
- MOUSE_DX  out  8  packet byte 2
- MOUSE_DY  out  8  packet byte 3
- SEND_INTERRUPT  out  1  one-cycle pulse when a full packet has been published
- INIT_DONE  out  1  high while in streaming states
- MASTER_STATE  out  4  current state encoding, for debug

Behaviour:
- Reset values: SEND_BYTE=0, BYTE_TO_SEND=00, READ_ENABLE=0, MOUSE_STATUS/DX/DY=00, SEND_INTERRUPT=0, INIT_DONE=0, state=S_STARTUP, all counters=0.
- RESET asserted mid-operation aborts everything in the next cycle. An in-flight transmit is abandoned; a late BYTE_SENT/BYTE_READY after reset is ignored by state.
- A single cycle counter cnt clears on every state change and saturates at its limit.
- States and encodings:
  - 0 S_STARTUP: wait until cnt==STARTUP_CYCLES-1, then go to S_SEND_RESET.
  - 1 S_SEND_RESET: BYTE_TO_SEND=FF, SEND_BYTE=1 for exactly one cycle, then go to S_WAIT_RESET_SENT.
  - 2 S_WAIT_RESET_SENT: on BYTE_SENT go to S_WAIT_ACK1.
  - 3 S_WAIT_ACK1: READ_ENABLE=1; BYTE_READY with error 00 and byte FA goes to S_WAIT_SELFTEST; any other byte/error goes to S_SEND_RESET.
  - 4 S_WAIT_SELFTEST: expects AA, same accept/reject rule, then S_WAIT_ID.
  - 5 S_WAIT_ID: expects 00, then S_SEND_ENABLE.
  - 6 S_SEND_ENABLE: BYTE_TO_SEND=F4, one-cycle SEND_BYTE, then S_WAIT_ENABLE_SENT.
  - 7 S_WAIT_ENABLE_SENT: on BYTE_SENT go to S_WAIT_ACK2.
  - 8 S_WAIT_ACK2: expects FA, then S_PKT1.
  - 9 S_PKT1: on good byte, latch into shadow status and go to S_PKT2.
  - 10 S_PKT2: on good byte, latch shadow dX and go to S_PKT3.
  - 11 S_PKT3: on good byte, latch shadow dY and go to S_PUBLISH.
  - 12 S_PUBLISH: one cycle; copy shadows to MOUSE_STATUS/DX/DY, SEND_INTERRUPT=1, go to S_PKT1.
- Timeouts: in states 2–8, cnt reaching TIMEOUT_CYCLES-1 goes to S_SEND_RESET. States 0–8 have INIT_DONE=0; states 9–12 have INIT_DONE=1.
- READ_ENABLE=1 in states 3–5 and 8–12; 0 elsewhere. It is deasserted while transmitting so the receiver ignores host-driven lines.
- Streaming error: BYTE_READY with nonzero BYTE_ERROR_CODE in S_PKT1..3 discards the partial packet and returns to S_PKT1. Outputs are unchanged and there is no interrupt.
- Published outputs change only in S_PUBLISH. They hold the last packet otherwise, including across init restarts (cleared only by RESET).
- BYTE_READY arriving in the same cycle as a timeout: the byte takes priority.
- BYTE_READY in a non-receiving state is ignored.

Optional Feature:
MOUSE_PKT_RESYNC_EN
- Defined:
  - In S_PKT1 a byte with bit3==0 is discarded; state stays in S_PKT1, to realign to the packet boundary.
  - In S_PKT2/S_PKT3, cnt reaching PKT_GAP_CYCLES-1 returns to S_PKT1 and drops the partial packet.
- Undefined: any error-free byte is accepted as byte 1, and there is no inter-byte timeout.

Test Plan:
- Test parameters for all scenarios: STARTUP_CYCLES=10, TIMEOUT_CYCLES=200, PKT_GAP_CYCLES=50.
- After reset, model acks BYTE_SENT, receiver returns FA, AA, 00, then FA after F4 -> SEND_BYTE pulses with FF then F4, INIT_DONE rises after the second FA, MASTER_STATE=9.
- In streaming, bytes 08, 05, FB -> one SEND_INTERRUPT pulse; STATUS=08, DX=05, DY=FB.
- Self-test byte returned as FC instead of AA -> returns to state 1, FF resent, INIT_DONE stays 0.
- No BYTE_READY after FF sent -> after 200 cycles FF resent; repeats indefinitely.
- Byte 2 arrives with BYTE_ERROR_CODE=01 -> no interrupt, outputs hold previous packet, next 3 good bytes publish normally.
- With MOUSE_PKT_RESYNC_EN: byte 00 in S_PKT1 then 09, 01, 02 -> STATUS=09, DX=01, DY=02. Byte1 followed by a 60-cycle gap -> partial packet dropped.
